mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch stage and its data-memory (MEM) stage. Each requester sees a request/ready handshake; the pipeline stalls the requesting stage while its request is high and its ready is low. MEM-stage requests win by default, and a starvation counter guarantees forward progress for fetch. The block also handles branch-flush abort of an in-flight fetch and a watchdog timeout on the memory response.

## Interface
Parameters:
- ADDR_W, 16, word-address width, matching the 16-bit PC.
- DATA_W, 32, data word width.
- FAIR_MAX, 4, consecutive data grants allowed while fetch waits. Range 1..15.
- TIMEOUT, 64, WAIT-state cycles before the watchdog fires. Range 2..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready or if_abort.
- if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
- if_abort  in  1  branch flush; cancels any pending or in-flight fetch.
- if_ready  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  one-cycle pulse; d_rdata is valid for reads.
- d_rdata  out  DATA_W  read data.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_valid.
- mem_valid  in  1  access complete; arrives 1 or more cycles after mem_en.
- err  out  1  sticky watchdog flag; cleared only by rst.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Sample d_req and (if_req && !if_abort).
  - If fair_cnt == FAIR_MAX and fetch is pending, grant fetch. Otherwise data wins when d_req is high.
  - Latch the granted address, we and wdata into the mem_* registers, latch owner, go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - mem_en = 1 for exactly this cycle. Go to WAIT.
- **WAIT**
  - On mem_valid: register mem_rdata into the owner's rdata, go to RESP.
  - Watchdog counts WAIT cycles. When it reaches TIMEOUT: set err, load rdata with 0, go to RESP.
- **RESP**
  - The owner's ready = 1 for one cycle. Requests sampled in this cycle are ignored. Go to IDLE.
- **Fairness counter (fair_cnt, 4 bits)**
  - Increments on a data grant while if_req is high.
  - Clears on a fetch grant, or on a data grant with if_req low.
  - Saturates at FAIR_MAX.
- **Fetch abort**
  - if_abort in IDLE: the fetch is not granted that cycle.
  - if_abort while owner = fetch in ISSUE, WAIT or RESP: set an abort flag. The memory access completes normally, but if_ready is suppressed.
  - Abort never affects a data transaction.
- mem_valid is ignored outside WAIT.
- Writes still wait for mem_valid. d_rdata is unchanged on a write.
- All state is flops; mem_* outputs are registered.

## Timing
- Reset values: state = IDLE; if_ready, d_ready, mem_en, mem_we, err = 0; all data/address outputs = 0; fair_cnt = 0; abort flag = 0.
- rst asserted mid-transaction returns to IDLE next cycle with no ready pulse. A late mem_valid is then ignored because the arbiter is in IDLE.
- Minimum latency, with the request sampled at cycle 0:
  - mem_en at cycle 1.
  - mem_valid at cycle 2 at the earliest.
  - ready at cycle 3.
- Back-to-back throughput: one transaction per 4 cycles at best.
- Simultaneous if_req and d_req with fair_cnt < FAIR_MAX: data is granted.
- Simultaneous if_abort and if_req in IDLE: no fetch grant.
- Watchdog expiry: ready is asserted TIMEOUT+1 cycles after entering WAIT.

## Test plan
- **Read latency.** Fetch-only read of addr 0x0010. Memory returns 0xDEADBEEF one cycle after mem_en. Required: mem_en at cycle 1, if_ready at cycle 3 with if_rdata = 0xDEADBEEF, d_ready never high.
- **Priority and fairness.** d_req and if_req held high continuously, FAIR_MAX = 4. Required: grants go D, D, D, D, F, D, D, D, D, F; fair_cnt returns to 0 after each fetch grant.
- **Fetch abort.** Fetch in WAIT, pulse if_abort, mem_valid arrives later. Required: no if_ready pulse and err = 0. A data request queued behind it is granted in the next IDLE.
- **Write.** d_we = 1, d_addr = 0x0100, d_wdata = 0x12345678. Required: mem_we = 1 with those values for exactly one mem_en cycle, d_ready pulses, d_rdata is unchanged.
- **Watchdog.** mem_valid is never asserted, TIMEOUT = 8. Required: d_ready pulses 9 cycles after entering WAIT with d_rdata = 0, err goes 1 and stays 1 until rst.
- **Reset mid-transaction.** rst in WAIT, then mem_valid the following cycle. Required: all outputs at reset values, no ready pulse, state remains IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// Data wins by default; a fairness counter and a response watchdog bound every wait.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_abort,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_valid,
  output logic              o_err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] FAIR_LIM = 4'(FAIR_MAX);
  localparam logic [7:0] WD_LIM   = 8'(TIMEOUT);

  state_t              r_state, w_state_next;
  logic                r_owner_if, w_owner_if_next;
  logic [3:0]          r_fair_cnt, w_fair_cnt_next;
  logic                r_abort, w_abort_next;
  logic [7:0]          r_wd_cnt, w_wd_cnt_next;
  logic                r_err, w_err_next;
  logic                r_mem_en, w_mem_en_next;
  logic                r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_next;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_next;
  logic                w_if_pend, w_grant_if, w_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_if  <= 1'b0;
      r_fair_cnt  <= '0;
      r_abort     <= 1'b0;
      r_wd_cnt    <= '0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner_if  <= w_owner_if_next;
      r_fair_cnt  <= w_fair_cnt_next;
      r_abort     <= w_abort_next;
      r_wd_cnt    <= w_wd_cnt_next;
      r_err       <= w_err_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_d_rdata   <= w_d_rdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_owner_if_next  = r_owner_if;
    w_fair_cnt_next  = r_fair_cnt;
    w_abort_next     = r_abort;
    w_wd_cnt_next    = r_wd_cnt;
    w_err_next       = r_err;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_d_rdata_next   = r_d_rdata;
    w_if_pend        = i_if_req && !i_if_abort;
    w_grant_if       = 1'b0;
    w_grant_d        = 1'b0;

    // A flush only marks a fetch already past arbitration; its access still runs out.
    if (r_owner_if && i_if_abort && (r_state != S_IDLE)) begin
      w_abort_next = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_if_pend && ((r_fair_cnt == FAIR_LIM) || !i_d_req)) begin
          w_grant_if = 1'b1;
        end else if (i_d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_if) begin
          w_owner_if_next  = 1'b1;
          w_mem_we_next    = 1'b0;
          w_mem_addr_next  = i_if_addr;
          w_mem_wdata_next = '0;
          w_fair_cnt_next  = '0;
        end
        if (w_grant_d) begin
          w_owner_if_next  = 1'b0;
          w_mem_we_next    = i_d_we;
          w_mem_addr_next  = i_d_addr;
          w_mem_wdata_next = i_d_wdata;
          if (!i_if_req) begin
            w_fair_cnt_next = '0;
          end else if (r_fair_cnt != FAIR_LIM) begin
            w_fair_cnt_next = r_fair_cnt + 4'd1;
          end
        end
        if (w_grant_if || w_grant_d) begin
          w_mem_en_next = 1'b1;
          w_wd_cnt_next = '0;
          w_state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_valid) begin
          if (r_owner_if) begin
            w_if_rdata_next = i_mem_rdata;
          end else if (!r_mem_we) begin
            w_d_rdata_next = i_mem_rdata;
          end
          w_state_next = S_RESP;
        end else if (r_wd_cnt == WD_LIM) begin
          w_err_next = 1'b1;
          if (r_owner_if) begin
            w_if_rdata_next = '0;
          end else if (!r_mem_we) begin
            w_d_rdata_next = '0;
          end
          w_state_next = S_RESP;
        end else begin
          w_wd_cnt_next = r_wd_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
        w_abort_next = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A flush arriving in the response cycle itself still suppresses the pulse.
  assign o_if_ready  = (r_state == S_RESP) && r_owner_if && !r_abort && !i_if_abort;
  assign o_d_ready   = (r_state == S_RESP) && !r_owner_if;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_err       = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int FAIR_MAX = 4;
  localparam int TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_if_req = 1'b0;
  logic [ADDR_W-1:0] i_if_addr = '0;
  logic              i_if_abort = 1'b0;
  logic              o_if_ready;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_d_req = 1'b0;
  logic              i_d_we = 1'b0;
  logic [ADDR_W-1:0] i_d_addr = '0;
  logic [DATA_W-1:0] i_d_wdata = '0;
  logic              o_d_ready;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata = '0;
  logic              i_mem_valid = 1'b0;
  logic              o_err;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FAIR_MAX(FAIR_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_abort(i_if_abort),
    .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: mode 0 fixed latency, 1 never answers, 3 random latency with stray valids.
  int          mem_mode = 0;
  int          lat_cfg = 1;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  int          rsp_cnt = -1;

  always begin
    @(negedge clk);
    if (o_mem_en === 1'b1) begin
      if (mem_mode == 1) rsp_cnt = -1;
      else if (mem_mode == 3) rsp_cnt = ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(1, 4));
      else rsp_cnt = lat_cfg;
    end
    @(posedge clk);
    #1;
    i_mem_valid = 1'b0;
    i_mem_rdata = (mem_mode == 3) ? $urandom : 32'h0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        i_mem_valid = 1'b1;
        i_mem_rdata = fixed_en ? fixed_data : $urandom;
        rsp_cnt = -1;
      end
    end else if (mem_mode == 3 && $urandom_range(0, 19) == 0) begin
      i_mem_valid = 1'b1;
    end
  end

  // Reference model: one transaction at a time, described by the cycle its access
  // strobe fires and the cycle its response is due.
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_own_if = 0;
  bit          m_aborted = 0;
  int          m_issue = 0;
  int          m_resp = -1;
  int          m_fair = 0;
  bit          m_err = 0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_fair = 0; m_err = 0; m_aborted = 0;
      m_if_rdata = '0; m_d_rdata = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (!m_busy) begin
      if (i_if_req && !i_if_abort && (m_fair == FAIR_MAX || !i_d_req)) begin
        m_busy = 1; m_own_if = 1; m_we = 1'b0; m_addr = i_if_addr; m_wdata = '0; m_fair = 0;
      end else if (i_d_req) begin
        m_busy = 1; m_own_if = 0; m_we = i_d_we; m_addr = i_d_addr; m_wdata = i_d_wdata;
        m_fair = i_if_req ? ((m_fair + 1 > FAIR_MAX) ? FAIR_MAX : m_fair + 1) : 0;
      end
      if (m_busy) begin
        m_issue = cyc + 1; m_resp = -1; m_aborted = 0;
      end
    end else begin
      if (m_own_if && i_if_abort) m_aborted = 1;
      if (cyc == m_resp) begin
        m_busy = 0;
      end else if (cyc > m_issue && m_resp < 0) begin
        if (i_mem_valid) begin
          m_resp = cyc + 1;
          if (m_own_if) m_if_rdata = i_mem_rdata;
          else if (!m_we) m_d_rdata = i_mem_rdata;
        end else if (cyc - m_issue - 1 == TIMEOUT) begin
          m_resp = cyc + 1; m_err = 1;
          if (m_own_if) m_if_rdata = '0;
          else if (!m_we) m_d_rdata = '0;
        end
      end
    end
    cyc++;
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_en, e_dr, e_ir;
      e_en = m_busy && (cyc == m_issue);
      e_dr = m_busy && (cyc == m_resp) && !m_own_if;
      e_ir = m_busy && (cyc == m_resp) && m_own_if && !m_aborted && !i_if_abort;
      chk("mem_en", o_mem_en, e_en);
      chk("d_ready", o_d_ready, e_dr);
      chk("if_ready", o_if_ready, e_ir);
      chk("err", o_err, m_err);
      chk("if_rdata", o_if_rdata, m_if_rdata);
      chk("d_rdata", o_d_rdata, m_d_rdata);
      if (e_en) begin
        chk("mem_we", o_mem_we, m_we);
        chk("mem_addr", o_mem_addr, m_addr);
        if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
      end
    end
  end

  // Long enough for any outstanding response to drain while held in reset.
  task automatic do_reset();
    rst = 1'b1; i_if_req = 1'b0; i_d_req = 1'b0; i_if_abort = 1'b0; i_d_we = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string seq;
    byte   gc;
    int    g, en_cyc, rdy_cyc, n_en;
    bit    saw, s_if, s_d, prev_abort;

    do_reset();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_if_ready", o_if_ready, 0); chk("rst_d_ready", o_d_ready, 0);
    chk("rst_mem_en", o_mem_en, 0);     chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0); chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_err", o_err, 0);           chk("rst_d_rdata", o_d_rdata, 0);
    next_cycle();

    // Read latency
    mem_mode = 0; lat_cfg = 1; fixed_en = 1'b1; fixed_data = 32'hDEADBEEF;
    i_if_addr = 16'h0010; i_if_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat_mem_en_c%0d", k), o_mem_en, (k == 1));
      chk($sformatf("lat_if_ready_c%0d", k), o_if_ready, (k == 3));
      chk($sformatf("lat_d_ready_c%0d", k), o_d_ready, 0);
      if (k == 1) chk("lat_mem_addr", o_mem_addr, 16'h0010);
      if (k == 3) chk("lat_if_rdata", o_if_rdata, 32'hDEADBEEF);
      next_cycle();
      if (k == 3) i_if_req = 1'b0;
    end

    // Priority and fairness with both requests held
    do_reset();
    fixed_en = 1'b0;
    seq = "DDDDFDDDDF";
    i_if_addr = 16'h0AAA; i_d_addr = 16'h0DDD; i_d_we = 1'b0;
    i_if_req = 1'b1; i_d_req = 1'b1;
    g = 0;
    for (int k = 0; k < 80 && g < 10; k++) begin
      @(negedge clk);
      if (o_mem_en) begin
        gc = (o_mem_addr == 16'h0AAA) ? "F" : "D";
        chk($sformatf("grant_%0d", g), gc, seq[g]);
        g++;
      end
      next_cycle();
    end
    if (g < 10) chk("fair_grant_count", g, 10);
    i_if_req = 1'b0; i_d_req = 1'b0;

    // Fetch abort with a data read queued behind it
    do_reset();
    lat_cfg = 5; fixed_en = 1'b1; fixed_data = 32'hCAFE0001;
    i_if_addr = 16'h0040; i_if_req = 1'b1;
    saw = 0; en_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_if_ready) saw = 1;
      if (k >= 2 && o_mem_en && en_cyc < 0) begin
        en_cyc = k;
        chk("abort_d_addr", o_mem_addr, 16'h0DD0);
      end
      if (k == 15) begin
        chk("abort_d_ready", o_d_ready, 1);
        chk("abort_d_rdata", o_d_rdata, 32'hCAFE0001);
      end
      next_cycle();
      if (k + 1 == 3) begin i_if_abort = 1'b1; i_d_req = 1'b1; i_d_addr = 16'h0DD0; i_d_we = 1'b0; end
      if (k + 1 == 4) begin i_if_abort = 1'b0; i_if_req = 1'b0; end
    end
    i_d_req = 1'b0;
    chk("abort_no_if_ready", saw, 0);
    chk("abort_err", o_err, 0);
    chk("abort_d_grant_cycle", en_cyc, 9);
    next_cycle();

    // Write leaves d_rdata alone
    lat_cfg = 1; fixed_en = 1'b0;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 16'h0100; i_d_wdata = 32'h12345678;
    n_en = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (o_mem_en) begin
        n_en++;
        chk("wr_en_cycle", k, 1);
        chk("wr_mem_we", o_mem_we, 1);
        chk("wr_mem_addr", o_mem_addr, 16'h0100);
        chk("wr_mem_wdata", o_mem_wdata, 32'h12345678);
      end
      if (k == 3) begin
        chk("wr_d_ready", o_d_ready, 1);
        chk("wr_d_rdata_kept", o_d_rdata, 32'hCAFE0001);
      end
      next_cycle();
      if (k == 3) begin i_d_req = 1'b0; i_d_we = 1'b0; end
    end
    chk("wr_en_count", n_en, 1);

    // Watchdog
    mem_mode = 1;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 16'h0200;
    rdy_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_d_ready && rdy_cyc < 0) rdy_cyc = k;
      if (k == 10) chk("wd_err_before", o_err, 0);
      if (k == 11) chk("wd_d_rdata", o_d_rdata, 0);
      if (k >= 11) chk($sformatf("wd_err_sticky_c%0d", k), o_err, 1);
      next_cycle();
      if (k == 11) i_d_req = 1'b0;
    end
    chk("wd_ready_cycle", rdy_cyc, 11);
    mem_mode = 0;
    do_reset();
    @(negedge clk);
    chk("wd_err_cleared", o_err, 0);
    next_cycle();

    // Reset in WAIT followed by a late mem_valid
    lat_cfg = 3;
    i_if_req = 1'b1; i_if_addr = 16'h0300;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk($sformatf("rstw_if_ready_c%0d", k), o_if_ready, 0);
        chk($sformatf("rstw_d_ready_c%0d", k), o_d_ready, 0);
        chk($sformatf("rstw_mem_en_c%0d", k), o_mem_en, 0);
        chk($sformatf("rstw_mem_addr_c%0d", k), o_mem_addr, 0);
        chk($sformatf("rstw_if_rdata_c%0d", k), o_if_rdata, 0);
      end
      if (k == 4) chk("rstw_late_valid_present", i_mem_valid, 1);
      next_cycle();
      if (k + 1 == 3) rst = 1'b1;
      if (k + 1 == 4) begin rst = 1'b0; i_if_req = 1'b0; end
    end

    // Random traffic
    mem_mode = 3; fixed_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_if = o_if_ready;
      s_d = o_d_ready;
      next_cycle();
      rst = ($urandom_range(0, 399) == 0);
      prev_abort = i_if_abort;
      i_if_abort = 1'b0;
      if (i_if_req) begin
        if (s_if || prev_abort) i_if_req = 1'b0;
        else if ($urandom_range(0, 23) == 0) i_if_abort = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        i_if_req = 1'b1;
        i_if_addr = 16'($urandom);
      end else if ($urandom_range(0, 29) == 0) begin
        i_if_abort = 1'b1;
      end
      if (i_d_req) begin
        if (s_d) i_d_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_d_req = 1'b1;
        i_d_we = 1'($urandom_range(0, 1));
        i_d_addr = 16'($urandom);
        i_d_wdata = $urandom;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
